// File: rtl/arb_pkg.sv
// Shared types for the round-robin bus arbiter.
// State encoding and the default hold limit.
package arb_pkg;

  localparam int STATE_W      = 2;
  localparam int DEF_MAX_HOLD = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker.
// Returns the first requester at or after ptr, wrapping modulo N.
module rr_pick
  import arb_pkg::*;
#(
  parameter int SEL_WIDTH = 2
) (
  input  logic [2**SEL_WIDTH-1:0] req,
  input  logic [SEL_WIDTH-1:0]    ptr,
  output logic [SEL_WIDTH-1:0]    win,
  output logic                    valid
);

  localparam int N = 2**SEL_WIDTH;

  logic [SEL_WIDTH-1:0] idx;

  // scan from the farthest offset down so the nearest to ptr wins
  always_comb begin
    win   = ptr;
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr + SEL_WIDTH'(i);
      if (req[idx]) begin
        win   = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with one-cycle turnaround between owners.
// Optional hold-limit preemption is built when ARB_TIMEOUT_EN is defined.
module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter int SEL_WIDTH = 2,
  parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [2**SEL_WIDTH-1:0] Req,
  output logic [2**SEL_WIDTH-1:0] Gnt,
  output logic [SEL_WIDTH-1:0]    Sel,
  output logic                    Busy,
  output logic                    Preempt
);

  localparam int N = 2**SEL_WIDTH;

  arb_state_e           state, state_n;
  logic [SEL_WIDTH-1:0] ptr, ptr_n;
  logic [SEL_WIDTH-1:0] sel_n, win;
  logic [N-1:0]         gnt_n;
  logic                 pick_ok;
  logic                 pre_n;
  logic                 timeout;

  rr_pick #(
    .SEL_WIDTH(SEL_WIDTH)
  ) u_pick (
    .req  (Req),
    .ptr  (ptr),
    .win  (win),
    .valid(pick_ok)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_cnt;

  // count owned cycles; zero outside OWN, stop at the limit
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hold_cnt <= '0;
    end else if (state != OWN) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // revoke only when someone else is waiting
  always_comb begin
    timeout = (state == OWN)
            && (hold_cnt == HOLD_LAST)
            && ((Req & ~Gnt) != '0);
  end
`else
  // no hold limit: the owner keeps the bus until it lets go
  always_comb begin
    timeout = 1'b0;
  end
`endif

  // next state, next grant and pointer update
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = Sel;
    gnt_n   = Gnt;
    pre_n   = 1'b0;
    unique case (state)
      OWN: begin
        if (!Req[Sel] || timeout) begin
          state_n = TURN;
          gnt_n   = '0;
          ptr_n   = Sel + SEL_WIDTH'(1);
          pre_n   = Req[Sel];
        end
      end
      default: begin
        gnt_n = '0;
        if (pick_ok) begin
          state_n    = OWN;
          gnt_n[win] = 1'b1;
          sel_n      = win;
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  // registered state and outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      ptr     <= '0;
      Gnt     <= '0;
      Sel     <= '0;
      Preempt <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      Gnt     <= gnt_n;
      Sel     <= sel_n;
      Preempt <= pre_n;
    end
  end

  // bus is busy exactly while an owner holds it
  always_comb begin
    Busy = (state == OWN);
  end

endmodule
